// File: rtl/fdma_axi_pkg.sv
// Shared encodings for the FDMA-to-AXI master: engine FSM states and AXI burst/response codes.
package fdma_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rstate_t;

endpackage

// File: rtl/fdma_burst_calc.sv
// Splits a transfer into bursts: length of the next burst, its AXI len field,
// and the address/remaining count that follow it.
module fdma_burst_calc #(
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ADDR_WIDTH = 29,
  parameter int MAX_BURST      = 64
) (
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic [15:0]               i_remain,
  output logic [7:0]                o_axlen,
  output logic [AXI_ADDR_WIDTH-1:0] o_next_addr,
  output logic [15:0]               o_next_remain
);

  localparam int SIZE_LOG2 = $clog2(AXI_DATA_WIDTH / 8);

  logic [15:0] w_len;

  assign w_len         = (i_remain > 16'(MAX_BURST)) ? 16'(MAX_BURST) : i_remain;
  assign o_axlen       = 8'(w_len - 16'd1);
  // Address arithmetic wraps naturally at the address width.
  assign o_next_addr   = i_addr + (AXI_ADDR_WIDTH'(w_len) << SIZE_LOG2);
  assign o_next_remain = i_remain - w_len;

endmodule

// File: rtl/fdma_axi_master.sv
// FDMA request port to AXI4 master bridge: independent write and read engines,
// each issuing INCR bursts of up to MAX_BURST beats, one burst outstanding at a time.
module fdma_axi_master
  import fdma_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ADDR_WIDTH = 29,
  parameter int MAX_BURST      = 64
) (
  input  logic                        I_ui_clk,
  input  logic                        I_ui_rst,
  input  logic [AXI_ADDR_WIDTH-1:0]   I_fdma_waddr,
  input  logic                        I_fdma_wareq,
  input  logic [15:0]                 I_fdma_wsize,
  output logic                        O_fdma_wbusy,
  output logic                        O_fdma_wvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   I_fdma_wdata,
  input  logic [AXI_ADDR_WIDTH-1:0]   I_fdma_raddr,
  input  logic                        I_fdma_rareq,
  input  logic [15:0]                 I_fdma_rsize,
  output logic                        O_fdma_rbusy,
  output logic                        O_fdma_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]   O_fdma_rdata,
  output logic                        O_fdma_werr,
  output logic                        O_fdma_rerr,
  output logic [AXI_ADDR_WIDTH-1:0]   O_m_axi_awaddr,
  output logic [7:0]                  O_m_axi_awlen,
  output logic [2:0]                  O_m_axi_awsize,
  output logic [1:0]                  O_m_axi_awburst,
  output logic                        O_m_axi_awvalid,
  input  logic                        I_m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   O_m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] O_m_axi_wstrb,
  output logic                        O_m_axi_wlast,
  output logic                        O_m_axi_wvalid,
  input  logic                        I_m_axi_wready,
  input  logic [1:0]                  I_m_axi_bresp,
  input  logic                        I_m_axi_bvalid,
  output logic                        O_m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   O_m_axi_araddr,
  output logic [7:0]                  O_m_axi_arlen,
  output logic [2:0]                  O_m_axi_arsize,
  output logic [1:0]                  O_m_axi_arburst,
  output logic                        O_m_axi_arvalid,
  input  logic                        I_m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   I_m_axi_rdata,
  input  logic [1:0]                  I_m_axi_rresp,
  input  logic                        I_m_axi_rlast,
  input  logic                        I_m_axi_rvalid,
  output logic                        O_m_axi_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

  wstate_t                   r_wstate, w_wstate_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_waddr;
  logic [15:0]               r_wremain;
  logic [7:0]                r_wlen_m1, r_wbeat;
  logic [7:0]                w_wcalc_axlen;
  logic [AXI_ADDR_WIDTH-1:0] w_wcalc_addr;
  logic [15:0]               w_wcalc_remain;

  rstate_t                   r_rstate, w_rstate_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_raddr;
  logic [15:0]               r_rremain;
  logic [7:0]                w_rcalc_axlen;
  logic [AXI_ADDR_WIDTH-1:0] w_rcalc_addr;
  logic [15:0]               w_rcalc_remain;

  logic w_aw_hs, w_w_hs, w_ar_hs;

  fdma_burst_calc #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .MAX_BURST(MAX_BURST)
  ) u_wcalc (
    .i_addr(r_waddr), .i_remain(r_wremain), .o_axlen(w_wcalc_axlen),
    .o_next_addr(w_wcalc_addr), .o_next_remain(w_wcalc_remain)
  );

  fdma_burst_calc #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .MAX_BURST(MAX_BURST)
  ) u_rcalc (
    .i_addr(r_raddr), .i_remain(r_rremain), .o_axlen(w_rcalc_axlen),
    .o_next_addr(w_rcalc_addr), .o_next_remain(w_rcalc_remain)
  );

  assign w_aw_hs = O_m_axi_awvalid & I_m_axi_awready;
  assign w_w_hs  = O_m_axi_wvalid & I_m_axi_wready;
  assign w_ar_hs = O_m_axi_arvalid & I_m_axi_arready;

  // ---------------- write engine ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_ui_clk or posedge I_ui_rst) begin
    if (I_ui_rst) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: if (I_fdma_wareq) w_wstate_nxt = W_ADDR;
      W_ADDR: if (r_wremain == 16'd0) w_wstate_nxt = W_IDLE;
              else if (w_aw_hs)       w_wstate_nxt = W_DATA;
      W_DATA: if (w_w_hs && O_m_axi_wlast) w_wstate_nxt = W_RESP;
      W_RESP: if (I_m_axi_bvalid) w_wstate_nxt = (r_wremain != 16'd0) ? W_ADDR : W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge I_ui_clk or posedge I_ui_rst) begin
    if (I_ui_rst) begin
      r_waddr   <= '0;
      r_wremain <= '0;
      r_wlen_m1 <= '0;
      r_wbeat   <= '0;
    end else if (r_wstate == W_IDLE && I_fdma_wareq) begin
      r_waddr   <= I_fdma_waddr;
      r_wremain <= I_fdma_wsize;
    end else if (r_wstate == W_ADDR && w_aw_hs) begin
      r_waddr   <= w_wcalc_addr;
      r_wremain <= w_wcalc_remain;
      r_wlen_m1 <= w_wcalc_axlen;
      r_wbeat   <= '0;
    end else if (w_w_hs) begin
      r_wbeat   <= r_wbeat + 8'd1;
    end
  end

  // Outputs are gated by state so they read all-zero in IDLE and during reset.
  always_comb begin
    O_m_axi_awvalid = 1'b0;
    O_m_axi_awaddr  = '0;
    O_m_axi_awlen   = '0;
    O_m_axi_awsize  = '0;
    O_m_axi_awburst = '0;
    O_m_axi_wvalid  = 1'b0;
    O_m_axi_wdata   = '0;
    O_m_axi_wstrb   = '0;
    O_m_axi_wlast   = 1'b0;
    O_m_axi_bready  = 1'b0;
    O_fdma_werr     = 1'b0;
    case (r_wstate)
      W_ADDR: if (r_wremain != 16'd0) begin
        O_m_axi_awvalid = 1'b1;
        O_m_axi_awaddr  = r_waddr;
        O_m_axi_awlen   = w_wcalc_axlen;
        O_m_axi_awsize  = AXSIZE;
        O_m_axi_awburst = BURST_INCR;
      end
      W_DATA: begin
        O_m_axi_wvalid = 1'b1;
        O_m_axi_wdata  = I_fdma_wdata;
        O_m_axi_wstrb  = '1;
        O_m_axi_wlast  = (r_wbeat == r_wlen_m1);
      end
      W_RESP: begin
        O_m_axi_bready = 1'b1;
        O_fdma_werr    = I_m_axi_bvalid & (I_m_axi_bresp != RESP_OKAY);
      end
      default: ;
    endcase
  end

  assign O_fdma_wbusy  = (r_wstate != W_IDLE);
  assign O_fdma_wvalid = w_w_hs;

  // ---------------- read engine ----------------
  always_ff @(posedge I_ui_clk or posedge I_ui_rst) begin
    if (I_ui_rst) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: if (I_fdma_rareq) w_rstate_nxt = R_ADDR;
      R_ADDR: if (r_rremain == 16'd0) w_rstate_nxt = R_IDLE;
              else if (w_ar_hs)       w_rstate_nxt = R_DATA;
      R_DATA: if (I_m_axi_rvalid && I_m_axi_rlast)
                w_rstate_nxt = (r_rremain != 16'd0) ? R_ADDR : R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge I_ui_clk or posedge I_ui_rst) begin
    if (I_ui_rst) begin
      r_raddr   <= '0;
      r_rremain <= '0;
    end else if (r_rstate == R_IDLE && I_fdma_rareq) begin
      r_raddr   <= I_fdma_raddr;
      r_rremain <= I_fdma_rsize;
    end else if (r_rstate == R_ADDR && w_ar_hs) begin
      r_raddr   <= w_rcalc_addr;
      r_rremain <= w_rcalc_remain;
    end
  end

  always_comb begin
    O_m_axi_arvalid = 1'b0;
    O_m_axi_araddr  = '0;
    O_m_axi_arlen   = '0;
    O_m_axi_arsize  = '0;
    O_m_axi_arburst = '0;
    O_m_axi_rready  = 1'b0;
    O_fdma_rvalid   = 1'b0;
    O_fdma_rdata    = '0;
    O_fdma_rerr     = 1'b0;
    case (r_rstate)
      R_ADDR: if (r_rremain != 16'd0) begin
        O_m_axi_arvalid = 1'b1;
        O_m_axi_araddr  = r_raddr;
        O_m_axi_arlen   = w_rcalc_axlen;
        O_m_axi_arsize  = AXSIZE;
        O_m_axi_arburst = BURST_INCR;
      end
      R_DATA: begin
        O_m_axi_rready = 1'b1;
        O_fdma_rvalid  = I_m_axi_rvalid;
        O_fdma_rdata   = I_m_axi_rdata;
        O_fdma_rerr    = I_m_axi_rvalid & (I_m_axi_rresp != RESP_OKAY);
      end
      default: ;
    endcase
  end

  assign O_fdma_rbusy = (r_rstate != R_IDLE);

endmodule

// File: tb/tb_fdma_axi_master.sv
// Directed bench for fdma_axi_master: a behavioural AXI slave/monitor plus a linear test sequence.
module tb_fdma_axi_master;

  localparam int DW = 256;
  localparam int AW = 29;

  logic          I_ui_clk = 1'b0;
  logic          I_ui_rst;
  logic [AW-1:0] I_fdma_waddr, I_fdma_raddr;
  logic          I_fdma_wareq, I_fdma_rareq;
  logic [15:0]   I_fdma_wsize, I_fdma_rsize;
  logic [DW-1:0] I_fdma_wdata;
  logic          O_fdma_wbusy, O_fdma_wvalid, O_fdma_rbusy, O_fdma_rvalid;
  logic [DW-1:0] O_fdma_rdata;
  logic          O_fdma_werr, O_fdma_rerr;
  logic [AW-1:0] O_m_axi_awaddr, O_m_axi_araddr;
  logic [7:0]    O_m_axi_awlen, O_m_axi_arlen;
  logic [2:0]    O_m_axi_awsize, O_m_axi_arsize;
  logic [1:0]    O_m_axi_awburst, O_m_axi_arburst;
  logic          O_m_axi_awvalid, I_m_axi_awready, O_m_axi_arvalid, I_m_axi_arready;
  logic [DW-1:0] O_m_axi_wdata, I_m_axi_rdata;
  logic [DW/8-1:0] O_m_axi_wstrb;
  logic          O_m_axi_wlast, O_m_axi_wvalid, I_m_axi_wready;
  logic [1:0]    I_m_axi_bresp, I_m_axi_rresp;
  logic          I_m_axi_bvalid, O_m_axi_bready;
  logic          I_m_axi_rlast, I_m_axi_rvalid, O_m_axi_rready;

  fdma_axi_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MAX_BURST(64)) dut (
    .I_ui_clk(I_ui_clk), .I_ui_rst(I_ui_rst),
    .I_fdma_waddr(I_fdma_waddr), .I_fdma_wareq(I_fdma_wareq), .I_fdma_wsize(I_fdma_wsize),
    .O_fdma_wbusy(O_fdma_wbusy), .O_fdma_wvalid(O_fdma_wvalid), .I_fdma_wdata(I_fdma_wdata),
    .I_fdma_raddr(I_fdma_raddr), .I_fdma_rareq(I_fdma_rareq), .I_fdma_rsize(I_fdma_rsize),
    .O_fdma_rbusy(O_fdma_rbusy), .O_fdma_rvalid(O_fdma_rvalid), .O_fdma_rdata(O_fdma_rdata),
    .O_fdma_werr(O_fdma_werr), .O_fdma_rerr(O_fdma_rerr),
    .O_m_axi_awaddr(O_m_axi_awaddr), .O_m_axi_awlen(O_m_axi_awlen), .O_m_axi_awsize(O_m_axi_awsize),
    .O_m_axi_awburst(O_m_axi_awburst), .O_m_axi_awvalid(O_m_axi_awvalid), .I_m_axi_awready(I_m_axi_awready),
    .O_m_axi_wdata(O_m_axi_wdata), .O_m_axi_wstrb(O_m_axi_wstrb), .O_m_axi_wlast(O_m_axi_wlast),
    .O_m_axi_wvalid(O_m_axi_wvalid), .I_m_axi_wready(I_m_axi_wready),
    .I_m_axi_bresp(I_m_axi_bresp), .I_m_axi_bvalid(I_m_axi_bvalid), .O_m_axi_bready(O_m_axi_bready),
    .O_m_axi_araddr(O_m_axi_araddr), .O_m_axi_arlen(O_m_axi_arlen), .O_m_axi_arsize(O_m_axi_arsize),
    .O_m_axi_arburst(O_m_axi_arburst), .O_m_axi_arvalid(O_m_axi_arvalid), .I_m_axi_arready(I_m_axi_arready),
    .I_m_axi_rdata(I_m_axi_rdata), .I_m_axi_rresp(I_m_axi_rresp), .I_m_axi_rlast(I_m_axi_rlast),
    .I_m_axi_rvalid(I_m_axi_rvalid), .O_m_axi_rready(O_m_axi_rready)
  );

  always #5 I_ui_clk = ~I_ui_clk;

  logic w_any_out;
  assign w_any_out = |{O_fdma_wbusy, O_fdma_wvalid, O_fdma_rbusy, O_fdma_rvalid, O_fdma_rdata,
                       O_fdma_werr, O_fdma_rerr, O_m_axi_awaddr, O_m_axi_awlen, O_m_axi_awsize,
                       O_m_axi_awburst, O_m_axi_awvalid, O_m_axi_wdata, O_m_axi_wstrb, O_m_axi_wlast,
                       O_m_axi_wvalid, O_m_axi_bready, O_m_axi_araddr, O_m_axi_arlen, O_m_axi_arsize,
                       O_m_axi_arburst, O_m_axi_arvalid, O_m_axi_rready};

  int cyc = 0;
  always @(posedge I_ui_clk) cyc <= cyc + 1;

  // Test controls (written only by the sequence) and monitor statistics (written only by the slave).
  bit stall_en;
  int slverr_at, rerr_at;
  int w_cnt, r_cnt, b_cnt, werr_cnt, rerr_cnt, data_err, wlast_err, proto_err;
  int last_b_cyc, last_rlast_cyc, pend_b, w_req_beat, rbeat;
  int aw_addr_q[$], aw_len_q[$], ar_addr_q[$], ar_len_q[$], r_q[$];
  bit b_hs, r_hs;
  int n_assert, n_fail;

  function automatic logic [DW-1:0] wpat(input int k);
    return {8{32'hA500_0000 + 32'(k)}};
  endfunction

  function automatic logic [DW-1:0] rpat(input int k);
    return {8{32'h5A00_0000 ^ 32'(k * 3)}};
  endfunction

  function automatic bit go();
    return stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  // Behavioural AXI slave and FDMA-side data source: sample on posedge, drive on negedge.
  always begin
    @(posedge I_ui_clk);
    if (I_ui_rst) begin
      pend_b = 0; w_req_beat = 0; rbeat = 0; b_hs = 0; r_hs = 0;
      r_q.delete();
    end else begin
      b_hs = I_m_axi_bvalid && O_m_axi_bready;
      r_hs = I_m_axi_rvalid && O_m_axi_rready;
      if (O_m_axi_awvalid && I_m_axi_awready) begin
        aw_addr_q.push_back(int'(O_m_axi_awaddr));
        aw_len_q.push_back(int'(O_m_axi_awlen));
        if (O_m_axi_awsize !== 3'd5 || O_m_axi_awburst !== 2'b01) proto_err++;
      end
      if (O_fdma_wvalid !== (O_m_axi_wvalid && I_m_axi_wready)) proto_err++;
      if (O_m_axi_wvalid && I_m_axi_wready) begin
        if (O_m_axi_wdata !== wpat(w_cnt)) data_err++;
        if (O_m_axi_wstrb !== {(DW/8){1'b1}}) proto_err++;
        if (O_m_axi_wlast !== (w_req_beat % 64 == 63)) wlast_err++;
        if (O_m_axi_wlast) pend_b++;
        w_cnt++;
        w_req_beat++;
      end
      if (b_hs) begin b_cnt++; pend_b--; last_b_cyc = cyc; end
      if (O_fdma_werr) werr_cnt++;
      if (O_m_axi_arvalid && I_m_axi_arready) begin
        ar_addr_q.push_back(int'(O_m_axi_araddr));
        ar_len_q.push_back(int'(O_m_axi_arlen));
        r_q.push_back(int'(O_m_axi_arlen));
        if (O_m_axi_arsize !== 3'd5 || O_m_axi_arburst !== 2'b01) proto_err++;
      end
      if (O_fdma_rvalid !== r_hs) proto_err++;
      if (r_hs) begin
        if (O_fdma_rdata !== rpat(r_cnt)) data_err++;
        r_cnt++;
        if (I_m_axi_rlast) begin
          last_rlast_cyc = cyc;
          rbeat = 0;
          if (r_q.size() > 0) void'(r_q.pop_front());
        end else rbeat++;
      end
      if (O_fdma_rerr) rerr_cnt++;
    end
    @(negedge I_ui_clk);
    if (I_ui_rst) begin
      I_m_axi_awready = 0; I_m_axi_wready = 0; I_m_axi_arready = 0;
      I_m_axi_bvalid = 0; I_m_axi_bresp = 0;
      I_m_axi_rvalid = 0; I_m_axi_rlast = 0; I_m_axi_rresp = 0; I_m_axi_rdata = '0;
    end else begin
      I_m_axi_awready = go();
      I_m_axi_wready  = go();
      I_m_axi_arready = go();
      if (b_hs) I_m_axi_bvalid = 0;
      if (!I_m_axi_bvalid && pend_b > 0 && go()) begin
        I_m_axi_bvalid = 1;
        I_m_axi_bresp  = (b_cnt == slverr_at) ? 2'b10 : 2'b00;
      end
      if (r_hs) begin I_m_axi_rvalid = 0; I_m_axi_rlast = 0; I_m_axi_rdata = '0; end
      if (!I_m_axi_rvalid && r_q.size() > 0 && go()) begin
        I_m_axi_rvalid = 1;
        I_m_axi_rdata  = rpat(r_cnt);
        I_m_axi_rlast  = (rbeat == r_q[0]);
        I_m_axi_rresp  = (r_cnt == rerr_at) ? 2'b10 : 2'b00;
      end
    end
    I_fdma_wdata = wpat(w_cnt);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int wfall, output int rfall);
    wfall = -1;
    rfall = -1;
    for (int i = 0; i < 20000 && (wfall < 0 || rfall < 0); i++) begin
      @(posedge I_ui_clk); #1;
      if (!O_fdma_wbusy && wfall < 0) wfall = cyc;
      if (!O_fdma_rbusy && rfall < 0) rfall = cyc;
    end
    check("idle_timeout", 64'(wfall >= 0 && rfall >= 0), 64'd1);
  endtask

  int aw0, ar0, w0, r0, b0, we0, re0, wfall, rfall;
  bit seen;

  initial begin
    I_ui_rst = 1; stall_en = 0; slverr_at = -1; rerr_at = -1;
    I_fdma_wareq = 0; I_fdma_rareq = 0; I_fdma_wsize = 0; I_fdma_rsize = 0;
    I_fdma_waddr = '0; I_fdma_raddr = '0;
    n_assert = 0; n_fail = 0;
    repeat (3) @(negedge I_ui_clk);
    check("reset_outputs_zero", 64'(w_any_out), 64'd0);
    I_ui_rst = 0;
    @(negedge I_ui_clk);

    // Concurrent write 640 @0x1000 and read 100 @0x2000, no stalls.
    aw0 = aw_addr_q.size(); ar0 = ar_addr_q.size(); w0 = w_cnt; r0 = r_cnt; b0 = b_cnt;
    we0 = werr_cnt; re0 = rerr_cnt;
    check("t1_wbusy_before", 64'(O_fdma_wbusy), 64'd0);
    check("t1_rbusy_before", 64'(O_fdma_rbusy), 64'd0);
    I_fdma_waddr = 29'h1000; I_fdma_wsize = 16'd640; I_fdma_wareq = 1;
    I_fdma_raddr = 29'h2000; I_fdma_rsize = 16'd100; I_fdma_rareq = 1;
    @(posedge I_ui_clk); #1;
    check("t1_wbusy_rise", 64'(O_fdma_wbusy), 64'd1);
    check("t1_rbusy_rise", 64'(O_fdma_rbusy), 64'd1);
    @(negedge I_ui_clk);
    I_fdma_wareq = 0; I_fdma_rareq = 0;
    repeat (5) @(negedge I_ui_clk);
    I_fdma_waddr = 29'h7000; I_fdma_wsize = 16'd64; I_fdma_wareq = 1;
    I_fdma_raddr = 29'h7000; I_fdma_rsize = 16'd64; I_fdma_rareq = 1;
    @(negedge I_ui_clk);
    I_fdma_wareq = 0; I_fdma_rareq = 0;
    wait_idle(wfall, rfall);
    check("t1_aw_count", 64'(aw_addr_q.size() - aw0), 64'd10);
    for (int k = 0; k < 10 && aw0 + k < aw_addr_q.size(); k++) begin
      check($sformatf("t1_awaddr[%0d]", k), 64'(aw_addr_q[aw0 + k]), 64'(32'h1000 + k * 32'h800));
      check($sformatf("t1_awlen[%0d]", k), 64'(aw_len_q[aw0 + k]), 64'd63);
    end
    check("t1_w_beats", 64'(w_cnt - w0), 64'd640);
    check("t1_b_count", 64'(b_cnt - b0), 64'd10);
    check("t1_wbusy_fall", 64'(wfall), 64'(last_b_cyc + 1));
    check("t1_ar_count", 64'(ar_addr_q.size() - ar0), 64'd2);
    if (ar_addr_q.size() >= ar0 + 2) begin
      check("t1_araddr0", 64'(ar_addr_q[ar0]), 64'h2000);
      check("t1_arlen0", 64'(ar_len_q[ar0]), 64'd63);
      check("t1_araddr1", 64'(ar_addr_q[ar0 + 1]), 64'h2800);
      check("t1_arlen1", 64'(ar_len_q[ar0 + 1]), 64'd35);
    end
    check("t1_r_beats", 64'(r_cnt - r0), 64'd100);
    check("t1_rbusy_fall", 64'(rfall), 64'(last_rlast_cyc + 1));
    check("t1_err_pulses", 64'((werr_cnt - we0) + (rerr_cnt - re0)), 64'd0);

    // Random stalls, SLVERR on the 2nd write burst and on read beat 70.
    @(negedge I_ui_clk);
    stall_en = 1;
    aw0 = aw_addr_q.size(); ar0 = ar_addr_q.size(); w0 = w_cnt; r0 = r_cnt; b0 = b_cnt;
    we0 = werr_cnt; re0 = rerr_cnt;
    slverr_at = b_cnt + 1; rerr_at = r_cnt + 70;
    I_fdma_waddr = 29'h0;     I_fdma_wsize = 16'd192; I_fdma_wareq = 1;
    I_fdma_raddr = 29'h40000; I_fdma_rsize = 16'd130; I_fdma_rareq = 1;
    @(negedge I_ui_clk);
    I_fdma_wareq = 0; I_fdma_rareq = 0;
    wait_idle(wfall, rfall);
    check("t2_aw_count", 64'(aw_addr_q.size() - aw0), 64'd3);
    for (int k = 0; k < 3 && aw0 + k < aw_addr_q.size(); k++)
      check($sformatf("t2_awaddr[%0d]", k), 64'(aw_addr_q[aw0 + k]), 64'(k * 32'h800));
    check("t2_w_beats", 64'(w_cnt - w0), 64'd192);
    check("t2_b_count", 64'(b_cnt - b0), 64'd3);
    check("t2_werr_pulses", 64'(werr_cnt - we0), 64'd1);
    check("t2_wbusy_fall", 64'(wfall), 64'(last_b_cyc + 1));
    check("t2_ar_count", 64'(ar_addr_q.size() - ar0), 64'd3);
    if (ar_addr_q.size() >= ar0 + 3) begin
      check("t2_araddr2", 64'(ar_addr_q[ar0 + 2]), 64'h41000);
      check("t2_arlen1", 64'(ar_len_q[ar0 + 1]), 64'd63);
      check("t2_arlen2", 64'(ar_len_q[ar0 + 2]), 64'd1);
    end
    check("t2_r_beats", 64'(r_cnt - r0), 64'd130);
    check("t2_rerr_pulses", 64'(rerr_cnt - re0), 64'd1);
    stall_en = 0; slverr_at = -1; rerr_at = -1;

    // Zero-size requests: one-cycle busy, no address phase.
    @(negedge I_ui_clk);
    aw0 = aw_addr_q.size(); ar0 = ar_addr_q.size();
    I_fdma_wsize = 16'd0; I_fdma_wareq = 1;
    I_fdma_rsize = 16'd0; I_fdma_rareq = 1;
    @(posedge I_ui_clk); #1;
    check("t3_wbusy_high", 64'(O_fdma_wbusy), 64'd1);
    check("t3_rbusy_high", 64'(O_fdma_rbusy), 64'd1);
    check("t3_no_axvalid", 64'({O_m_axi_awvalid, O_m_axi_arvalid}), 64'd0);
    @(negedge I_ui_clk);
    I_fdma_wareq = 0; I_fdma_rareq = 0;
    @(posedge I_ui_clk); #1;
    check("t3_wbusy_low", 64'(O_fdma_wbusy), 64'd0);
    check("t3_rbusy_low", 64'(O_fdma_rbusy), 64'd0);
    repeat (5) @(posedge I_ui_clk); #1;
    check("t3_no_aw_ar", 64'((aw_addr_q.size() - aw0) + (ar_addr_q.size() - ar0)), 64'd0);

    // Reset asserted mid-DATA, then a fresh request.
    @(negedge I_ui_clk);
    I_fdma_waddr = 29'h3000; I_fdma_wsize = 16'd64; I_fdma_wareq = 1;
    @(negedge I_ui_clk);
    I_fdma_wareq = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge I_ui_clk); #1;
      seen = O_m_axi_wvalid;
    end
    check("t4_reached_data", 64'(seen), 64'd1);
    repeat (3) @(posedge I_ui_clk);
    #1 I_ui_rst = 1;
    #1 check("t4_rst_outputs_zero", 64'(w_any_out), 64'd0);
    repeat (2) @(negedge I_ui_clk);
    I_ui_rst = 0;
    @(negedge I_ui_clk);
    aw0 = aw_addr_q.size(); w0 = w_cnt; b0 = b_cnt;
    I_fdma_waddr = 29'h3000; I_fdma_wsize = 16'd64; I_fdma_wareq = 1;
    @(negedge I_ui_clk);
    I_fdma_wareq = 0;
    wait_idle(wfall, rfall);
    check("t4_aw_count", 64'(aw_addr_q.size() - aw0), 64'd1);
    if (aw_addr_q.size() > aw0) begin
      check("t4_awaddr", 64'(aw_addr_q[aw0]), 64'h3000);
      check("t4_awlen", 64'(aw_len_q[aw0]), 64'd63);
    end
    check("t4_w_beats", 64'(w_cnt - w0), 64'd64);
    check("t4_b_count", 64'(b_cnt - b0), 64'd1);

    check("data_order_errors", 64'(data_err), 64'd0);
    check("wlast_errors", 64'(wlast_err), 64'd0);
    check("protocol_errors", 64'(proto_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
